// File: rtl/noc_pkt_tx_pkg.sv
// Shared types and constants for the NoC packet transmitter.
package noc_pkg;

  localparam int XY_SZ_D  = 4;
  localparam int LEN_W_D  = 8;
  localparam int TYPE_W   = 8;
  localparam int SRC_W    = 2 * XY_SZ_D;
  localparam int WORD_W   = 32;
  localparam int KEEP_W   = WORD_W / 8;
  localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

  // Header layout, LSB-first: x, y, src, len, type.
  typedef struct packed {
    logic [TYPE_W-1:0]  typ;
    logic [LEN_W_D-1:0] len;
    logic [SRC_W-1:0]   src;
    logic [XY_SZ_D-1:0] y;
    logic [XY_SZ_D-1:0] x;
  } noc_hdr_t;

  localparam int HDR_W_D = $bits(noc_hdr_t);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } tx_state_t;

endpackage

// File: rtl/noc_pkt_tx_if.sv
// Request, payload and egress stream bundle for the packet transmitter.
interface noc_pkt_tx_if #(
  parameter int XY_SZ = 4,
  parameter int LEN_W = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [XY_SZ-1:0] req_x_dest;
  logic [XY_SZ-1:0] req_y_dest;
  logic [7:0]       req_type;
  logic [LEN_W-1:0] req_len;

  logic             pld_valid;
  logic [31:0]      pld_data;
  logic             pld_ready;

  logic             stream_out_TREADY;
  logic             stream_out_TVALID;
  logic [31:0]      stream_out_TDATA;
  logic [3:0]       stream_out_TKEEP;
  logic             stream_out_TLAST;

  // Environment side: issues requests and payload, sinks the stream.
  modport master (
    output req_valid, req_x_dest, req_y_dest, req_type, req_len,
    output pld_valid, pld_data,
    output stream_out_TREADY,
    input  req_ready, pld_ready,
    input  stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
  );

  // Transmitter side.
  modport slave (
    input  req_valid, req_x_dest, req_y_dest, req_type, req_len,
    input  pld_valid, pld_data,
    input  stream_out_TREADY,
    output req_ready, pld_ready,
    output stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
  );

endinterface

// File: rtl/noc_pkt_tx.sv
// NoC egress framer: one header word, then req_len payload words, TLAST on
// the final word, through a single registered output slot.
module noc_pkt_tx
  import noc_pkg::*;
#(
  parameter int XY_SZ = XY_SZ_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_high,
  input  logic [2*XY_SZ-1:0] HsrcId,
  noc_pkt_tx_if.slave        bus,
  output logic               busy,
  output logic [15:0]        pkts_sent
);

  localparam int HDR_W = TYPE_W + LEN_W + 4 * XY_SZ;

  tx_state_t        r_state, w_state_nxt;
  logic             r_tvalid;
  logic [31:0]      r_tdata;
  logic [3:0]       r_tkeep;
  logic             r_tlast;
  logic [LEN_W-1:0] r_cnt;
  logic [15:0]      r_pkts;

  logic             w_out_free;
  logic             w_req_ready;
  logic             w_pld_ready;
  logic             w_load_hdr;
  logic             w_load_pld;
  logic             w_cnt_last;
  logic [HDR_W-1:0] w_hdr_raw;
  logic [31:0]      w_hdr;

  // Slot can take a new word when empty or draining this cycle.
  assign w_out_free = !r_tvalid || bus.stream_out_TREADY;
  assign w_cnt_last = (r_cnt == LEN_W'(1));
  assign w_hdr_raw  = {bus.req_type, bus.req_len, HsrcId, bus.req_y_dest, bus.req_x_dest};
  assign w_hdr      = 32'(w_hdr_raw);

  assign w_load_hdr = bus.req_valid && w_req_ready;
  assign w_load_pld = bus.pld_valid && w_pld_ready;

  // Next state and handshake readies; readies are held low during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_pld_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = w_out_free && !clk_line_rst_high;
        if (bus.req_valid && w_req_ready && (bus.req_len != '0))
          w_state_nxt = DATA;
      end
      DATA: begin
        w_pld_ready = w_out_free && !clk_line_rst_high;
        if (bus.pld_valid && w_pld_ready && w_cnt_last)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) r_state <= IDLE;
    else                   r_state <= w_state_nxt;
  end

  // Output slot: load header or payload, hold on stall, empty when drained.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_load_hdr) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_hdr;
      r_tkeep  <= KEEP_ALL;
      r_tlast  <= (bus.req_len == '0);
    end else if (w_load_pld) begin
      r_tvalid <= 1'b1;
      r_tdata  <= bus.pld_data;
      r_tkeep  <= KEEP_ALL;
      r_tlast  <= w_cnt_last;
    end else if (w_out_free) begin
      r_tvalid <= 1'b0;
    end
  end

  // Remaining payload word counter, latched from the accepted request.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high)  r_cnt <= '0;
    else if (w_load_hdr)    r_cnt <= bus.req_len;
    else if (w_load_pld)    r_cnt <= r_cnt - LEN_W'(1);
  end

  // Completed-packet counter, bumped on each TLAST handshake; wraps.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high)
      r_pkts <= '0;
    else if (r_tvalid && bus.stream_out_TREADY && r_tlast)
      r_pkts <= r_pkts + 16'd1;
  end

  assign bus.req_ready         = w_req_ready;
  assign bus.pld_ready         = w_pld_ready;
  assign bus.stream_out_TVALID = r_tvalid;
  assign bus.stream_out_TDATA  = r_tdata;
  assign bus.stream_out_TKEEP  = r_tkeep;
  assign bus.stream_out_TLAST  = r_tlast;
  assign busy                  = (r_state != IDLE) || r_tvalid;
  assign pkts_sent             = r_pkts;

endmodule
